// File: rtl/core_dbus_if.sv
// -----------------------------------------------------------------------------
// core_dbus_if
// Peripheral bus between the memory-stage bridge (master) and the MMIO fabric
// (slave). One request/acknowledge transaction at a time.
//   bus_req   master->slave  request, held until completion
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  doubleword-aligned address
//   bus_wdata master->slave  lane-positioned store data
//   bus_wstrb master->slave  byte strobes
//   bus_ack   slave->master  transaction complete (sampled on posedge)
//   bus_err   slave->master  error, qualified by bus_ack
//   bus_rdata slave->master  read data, qualified by bus_ack
// -----------------------------------------------------------------------------
interface core_dbus_if;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wstrb;
   logic        bus_ack;
   logic        bus_err;
   logic [63:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_err, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_err, bus_rdata
   );
endinterface

// File: rtl/core_dbus.sv
// -----------------------------------------------------------------------------
// core_dbus
// Memory-stage data-bus bridge. Loads/stores hitting the MMIO window are run as
// request/acknowledge transactions on the peripheral bus while the pipeline is
// stalled; load data is lane-extracted and sign/zero-extended for core_MEM.
// Ports:
//   clock, reset        pipeline clock, asynchronous active-high reset
//   addr, wdata         effective address and store data from EX
//   mem_load_type       00 none, 01 byte, 10 word, 11 dword
//   mem_store_type      same encoding; a store wins if both are nonzero
//   load_signed         sign-extend byte/word loads
//   flush               pipeline flush; blocks acceptance, kills in-flight result
//   stall               freeze PC/IF/ID/EX
//   d_valid, d_rdata    MMIO load data to core_MEM
//   d_ready             this instruction is owned by the MMIO path
//   d_err               one-cycle error pulse (misaligned, bus error, timeout)
//   bus                 peripheral bus, master side
// -----------------------------------------------------------------------------
module core_dbus #(
   parameter logic [63:0] MMIO_BASE = 64'hFFFF_FFFF_FFFF_0000,
   parameter int unsigned MMIO_LOG2 = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [63:0]       addr,
   input  logic [63:0]       wdata,
   input  logic [1:0]        mem_load_type,
   input  logic [1:0]        mem_store_type,
   input  logic              load_signed,
   input  logic              flush,
   output logic              stall,
   output logic              d_valid,
   output logic              d_ready,
   output logic [63:0]       d_rdata,
   output logic              d_err,
   core_dbus_if.master       bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

   localparam logic [1:0] SZ_BYTE  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   logic [1:0]        state_q,     state_d;
   logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
   logic              killed_q,    killed_d;
   logic              err_q,       err_d;
   logic [63:0]       rdata_q,     rdata_d;
   logic [2:0]        lane_q,      lane_d;
   logic [1:0]        size_q,      size_d;
   logic              signed_q,    signed_d;
   logic              we_q,        we_d;
   logic [63:0]       bus_addr_q,  bus_addr_d;
   logic              bus_we_q,    bus_we_d;
   logic [63:0]       bus_wdata_q, bus_wdata_d;
   logic [7:0]        bus_wstrb_q, bus_wstrb_d;

   logic              is_store_s;
   logic [1:0]        size_s;
   logic              hit_s;
   logic              misaligned_s;
   logic [7:0]        strb_s;
   logic [63:0]       lane_wdata_s;
   logic              idle_hit_s;
   logic              in_req_s;
   logic              in_done_s;
   logic [7:0]        byte_s;
   logic [31:0]       word_s;

   // Decode the incoming access: size, window hit, alignment, lane data.
   always_comb begin
      is_store_s = (mem_store_type != 2'b00);
      if (is_store_s) begin
         size_s = mem_store_type;
      end else begin
         size_s = mem_load_type;
      end
      // Flush wins over a hit so a squashed instruction never starts a transaction.
      hit_s = (size_s != 2'b00) &&
              (addr[63:MMIO_LOG2] == MMIO_BASE[63:MMIO_LOG2]) && !flush;
      misaligned_s = ((size_s == SZ_WORD)  && (addr[1:0] != 2'b00)) ||
                     ((size_s == SZ_DWORD) && (addr[2:0] != 3'b000));
      case (size_s)
         SZ_BYTE: begin
            strb_s       = 8'b0000_0001 << addr[2:0];
            lane_wdata_s = {8{wdata[7:0]}};
         end
         SZ_WORD: begin
            strb_s       = addr[2] ? 8'hF0 : 8'h0F;
            lane_wdata_s = {2{wdata[31:0]}};
         end
         SZ_DWORD: begin
            strb_s       = 8'hFF;
            lane_wdata_s = wdata;
         end
         default: begin
            strb_s       = 8'h00;
            lane_wdata_s = 64'h0;
         end
      endcase
   end

   // Next-state logic of the IDLE/REQ/DONE sequencer and its captured context.
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      killed_d    = killed_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      lane_d      = lane_q;
      size_d      = size_q;
      signed_d    = signed_q;
      we_d        = we_q;
      bus_addr_d  = bus_addr_q;
      bus_we_d    = bus_we_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      case (state_q)
         ST_IDLE: begin
            if (hit_s) begin
               lane_d   = addr[2:0];
               size_d   = size_s;
               signed_d = load_signed;
               we_d     = is_store_s;
               killed_d = 1'b0;
               tcnt_d   = '0;
               if (misaligned_s) begin
                  // Completes with an error without touching the bus.
                  err_d   = 1'b1;
                  rdata_d = 64'h0;
                  state_d = ST_DONE;
               end else begin
                  err_d       = 1'b0;
                  bus_addr_d  = {addr[63:3], 3'b000};
                  bus_we_d    = is_store_s;
                  bus_wdata_d = lane_wdata_s;
                  bus_wstrb_d = strb_s;
                  state_d     = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // The transaction still runs to completion; only its result is dropped.
            if (flush) begin
               killed_d = 1'b1;
            end else begin
               killed_d = killed_q;
            end
            if (bus.bus_ack) begin
               rdata_d = bus.bus_rdata;
               err_d   = bus.bus_err;
               state_d = ST_DONE;
            end else if (tcnt_q == TCNT_MAX) begin
               rdata_d = 64'h0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and context registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         killed_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 64'h0;
         lane_q      <= 3'b000;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         we_q        <= 1'b0;
         bus_addr_q  <= 64'h0;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= 64'h0;
         bus_wstrb_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         killed_q    <= killed_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         lane_q      <= lane_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         we_q        <= we_d;
         bus_addr_q  <= bus_addr_d;
         bus_we_q    <= bus_we_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
      end
   end

   // Lane extraction and extension of the captured read data.
   always_comb begin
      byte_s = rdata_q[{lane_q, 3'b000} +: 8];
      if (lane_q[2]) begin
         word_s = rdata_q[63:32];
      end else begin
         word_s = rdata_q[31:0];
      end
      if (err_q) begin
         d_rdata = 64'h0;
      end else begin
         case (size_q)
            SZ_BYTE:  d_rdata = {{56{signed_q & byte_s[7]}}, byte_s};
            SZ_WORD:  d_rdata = {{32{signed_q & word_s[31]}}, word_s};
            SZ_DWORD: d_rdata = rdata_q;
            default:  d_rdata = 64'h0;
         endcase
      end
   end

   // Pipeline handshake; reset forces everything quiet even while EX holds a hit.
   always_comb begin
      idle_hit_s = (state_q == ST_IDLE) && hit_s;
      in_req_s   = (state_q == ST_REQ);
      in_done_s  = (state_q == ST_DONE) && !killed_q;
      if (reset) begin
         stall   = 1'b0;
         d_ready = 1'b0;
         d_valid = 1'b0;
         d_err   = 1'b0;
      end else begin
         stall   = idle_hit_s || in_req_s;
         d_ready = idle_hit_s || in_req_s || in_done_s;
         d_valid = in_done_s && !we_q;
         d_err   = in_done_s && err_q;
      end
   end

   // bus_req follows the state register, so the async reset drops it at once.
   assign bus.bus_req   = (state_q == ST_REQ);
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign bus.bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_core_dbus.sv
// -----------------------------------------------------------------------------
// tb_core_dbus
// Self-checking bench for core_dbus: directed scenarios plus randomized
// accesses, checked cycle by cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_core_dbus;

   localparam int TMO = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [1:0]  mem_load_type;
   logic [1:0]  mem_store_type;
   logic        load_signed;
   logic        flush;
   logic        stall;
   logic        d_valid;
   logic        d_ready;
   logic [63:0] d_rdata;
   logic        d_err;

   int n_cmp = 0;
   int n_mis = 0;

   core_dbus_if bus_if ();

   core_dbus dut (
      .clock          (clock),
      .reset          (reset),
      .addr           (addr),
      .wdata          (wdata),
      .mem_load_type  (mem_load_type),
      .mem_store_type (mem_store_type),
      .load_signed    (load_signed),
      .flush          (flush),
      .stall          (stall),
      .d_valid        (d_valid),
      .d_ready        (d_ready),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .bus            (bus_if)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_idle();
      addr           = 64'h0;
      wdata          = 64'h0;
      mem_load_type  = 2'b00;
      mem_store_type = 2'b00;
      load_signed    = 1'b0;
      flush          = 1'b0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_err   = 1'b0;
      bus_if.bus_rdata = 64'h0;
   endtask

   // Reference: value core_MEM should see for a completed load.
   function automatic logic [63:0] model_load(input logic [63:0] a, input logic [63:0] rd,
                                              input logic [1:0] size, input logic sgn);
      logic [63:0] b;
      logic [63:0] w;
      b = (rd >> (8 * a[2:0])) & 64'hFF;
      w = a[2] ? (rd >> 32) : (rd & 64'hFFFF_FFFF);
      if (size == 2'd1) begin
         return (sgn && b >= 64'd128) ? b - 64'd256 : b;
      end else if (size == 2'd2) begin
         return (sgn && w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w;
      end else begin
         return rd;
      end
   endfunction

   // One instruction through the memory stage. k = ack cycle within REQ (1 = first
   // REQ cycle, 0 = never); fl_at = REQ cycle carrying a flush (0 = none).
   task automatic run_access(input logic [63:0] a, input logic [63:0] wd,
                             input logic [1:0] lt, input logic [1:0] st, input logic sgn,
                             input int k, input logic berr, input logic [63:0] brd,
                             input int fl_at);
      logic        win, is_store, mis, killed, err;
      logic [1:0]  size;
      logic [7:0]  strb;
      logic [63:0] wexp;
      win      = (a[63:16] == 48'hFFFF_FFFF_FFFF);
      is_store = (st != 2'b00);
      size     = is_store ? st : lt;
      mis      = (size == 2'd2 && a[1:0] != 2'b00) || (size == 2'd3 && a[2:0] != 3'b000);
      strb     = (size == 2'd1) ? (8'h01 << a[2:0]) : (size == 2'd2) ? (a[2] ? 8'hF0 : 8'h0F) : 8'hFF;
      wexp     = (size == 2'd1) ? wd[7:0] * 64'h0101_0101_0101_0101 :
                 (size == 2'd2) ? wd[31:0] * 64'h0000_0001_0000_0001 : wd;
      killed   = 1'b0;
      err      = 1'b0;

      tick();
      addr = a; wdata = wd; mem_load_type = lt; mem_store_type = st;
      load_signed = sgn; flush = 1'b0;
      bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
      #1;
      if (!win || size == 2'b00) begin
         check_val("bypass_stall", stall, 1'b0);
         check_val("bypass_ready", d_ready, 1'b0);
         check_val("bypass_valid", d_valid, 1'b0);
         tick();
         check_val("bypass_req", bus_if.bus_req, 1'b0);
      end else begin
         check_val("accept_stall", stall, 1'b1);
         check_val("accept_ready", d_ready, 1'b1);
         check_val("accept_req", bus_if.bus_req, 1'b0);
         if (mis) begin
            err = 1'b1;
         end else begin
            for (int n = 1; n <= TMO + 1; n++) begin
               tick();
               bus_if.bus_ack   = (n == k);
               bus_if.bus_err   = berr;
               bus_if.bus_rdata = (n == k) ? brd : {$urandom, $urandom};
               flush            = (n == fl_at);
               #1;
               if (n == 1 || n == k) begin
                  check_val("req_req", bus_if.bus_req, 1'b1);
                  check_val("req_stall", stall, 1'b1);
                  check_val("req_ready", d_ready, 1'b1);
                  check_val("req_valid", d_valid, 1'b0);
                  check_val("req_addr", bus_if.bus_addr, {a[63:3], 3'b000});
                  check_val("req_we", bus_if.bus_we, is_store);
                  check_val("req_wstrb", bus_if.bus_wstrb, strb);
                  if (is_store) check_val("req_wdata", bus_if.bus_wdata, wexp);
               end
               if (n == fl_at) killed = 1'b1;
               if (n == k) begin
                  err = berr;
                  break;
               end
               if (n == TMO + 1) err = 1'b1;
            end
         end
         // DONE cycle: the pipeline still holds the same instruction.
         tick();
         bus_if.bus_ack = 1'b0; flush = 1'b0; bus_if.bus_rdata = {$urandom, $urandom};
         #1;
         check_val("done_stall", stall, 1'b0);
         check_val("done_req", bus_if.bus_req, 1'b0);
         check_val("done_valid", d_valid, !is_store && !killed);
         check_val("done_ready", d_ready, !killed);
         check_val("done_err", d_err, err && !killed);
         if (!mis) check_val("done_addr", bus_if.bus_addr, {a[63:3], 3'b000});
         if (!is_store && !killed) begin
            check_val("done_rdata", d_rdata, err ? 64'h0 : model_load(a, brd, size, sgn));
         end
         tick();
      end
      set_idle();
      #1;
      check_val("after_req", bus_if.bus_req, 1'b0);
      check_val("after_stall", stall, 1'b0);
      check_val("after_valid", d_valid, 1'b0);
   endtask

   initial begin
      logic [63:0] ra;
      logic [1:0]  rl, rs;
      int          rk, rf;
      set_idle();
      #2;
      check_val("rst_req", bus_if.bus_req, 1'b0);
      check_val("rst_addr", bus_if.bus_addr, 64'h0);
      check_val("rst_wstrb", bus_if.bus_wstrb, 8'h00);
      check_val("rst_stall", stall, 1'b0);
      tick();
      reset = 1'b0;

      // Signed byte load from lane 4, ack in first REQ cycle.
      run_access(64'hFFFF_FFFF_FFFF_0014, 64'h0, 2'b01, 2'b00, 1'b1, 1, 1'b0,
                 64'h0000_0080_0000_0000, 0);
      // Word store to the upper half, ack in third REQ cycle.
      run_access(64'hFFFF_FFFF_FFFF_0004, 64'h1234_5678, 2'b00, 2'b10, 1'b0, 3, 1'b0, 64'h0, 0);
      // No ack: timeout.
      run_access(64'hFFFF_FFFF_FFFF_0008, 64'h0, 2'b11, 2'b00, 1'b0, 0, 1'b0, 64'h0, 0);
      // Misaligned dword load.
      run_access(64'hFFFF_FFFF_FFFF_0003, 64'h0, 2'b11, 2'b00, 1'b0, 1, 1'b0, 64'h0, 0);
      // Flush during REQ, ack in second REQ cycle.
      run_access(64'hFFFF_FFFF_FFFF_0020, 64'h0, 2'b10, 2'b00, 1'b1, 2, 1'b0,
                 64'h8765_4321_FEDC_BA98, 1);
      // Bus error on a signed word load.
      run_access(64'hFFFF_FFFF_FFFF_0030, 64'h0, 2'b10, 2'b00, 1'b1, 2, 1'b1, 64'hFFFF_FFFF, 0);

      // Flush coinciding with a hit in IDLE.
      tick();
      addr = 64'hFFFF_FFFF_FFFF_0040; mem_load_type = 2'b01; flush = 1'b1;
      #1;
      check_val("flush_idle_stall", stall, 1'b0);
      check_val("flush_idle_ready", d_ready, 1'b0);
      tick();
      check_val("flush_idle_req", bus_if.bus_req, 1'b0);
      set_idle();

      // Reset in the middle of REQ.
      tick();
      addr = 64'hFFFF_FFFF_FFFF_0048; mem_load_type = 2'b11;
      tick();
      tick();
      check_val("pre_rst_req", bus_if.bus_req, 1'b1);
      reset = 1'b1;
      #1;
      check_val("mid_rst_req", bus_if.bus_req, 1'b0);
      check_val("mid_rst_stall", stall, 1'b0);
      tick();
      reset = 1'b0;
      set_idle();
      run_access(64'h0000_0000_0000_0100, 64'h0, 2'b01, 2'b00, 1'b0, 1, 1'b0, 64'h0, 0);

      // Randomized accesses.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            ra = {48'hFFFF_FFFF_FFFF, 16'($urandom)};
            if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
         end else begin
            ra = {$urandom, $urandom};
         end
         rl = 2'($urandom_range(0, 3));
         rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rk = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         rf = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 3) : 0;
         if (rk != 0 && rf > rk) rf = 0;
         run_access(ra, {$urandom, $urandom}, rl, rs, 1'($urandom_range(0, 1)), rk,
                    ($urandom_range(0, 4) == 0), {$urandom, $urandom}, rf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/core_dbus.md
# core_dbus

Memory-stage data-bus bridge that sits between the EX pipeline register and core_MEM. It detects loads and stores that target the MMIO window and runs them as request/acknowledge transactions on the peripheral bus, stalling the pipeline while each transaction is in flight. It returns lane-extracted, sign-extended load data to core_MEM on d_rdata/d_valid. It holds d_ready high for the whole access so core_MEM suppresses its local data_mem store.

## Interface
Parameters:
- MMIO_BASE, 64'hFFFF_FFFF_FFFF_0000, base of the MMIO window; must be aligned to 2^MMIO_LOG2.
- MMIO_LOG2, 16, log2 of the window size; hit is addr[63:MMIO_LOG2] == MMIO_BASE[63:MMIO_LOG2].
- TIMEOUT, 255, maximum REQ cycles without bus_ack before a forced error completion.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- addr  in  64  EX_regs.out, effective address
- wdata  in  64  EX_regs.B_data, store data (low bits significant)
- mem_load_type  in  2  00 none, 01 byte, 10 word (32 b), 11 dword
- mem_store_type  in  2  same encoding
- load_signed  in  1  sign-extend byte/word loads
- flush  in  1  pipeline flush; blocks acceptance
- stall  out  1  freeze PC/IF/ID/EX registers
- d_valid  out  1  MMIO load data valid to core_MEM
- d_ready  out  1  MMIO access owns this instruction; suppresses data_mem store
- d_rdata  out  64  extracted load data
- d_err  out  1  one-cycle pulse: misaligned, bus error or timeout
- bus_req  out  1  transaction request, held until completion
- bus_we  out  1  1 = write
- bus_addr  out  64  {addr[63:3], 3'b000}
- bus_wdata  out  64  lane-positioned store data
- bus_wstrb  out  8  byte strobes
- bus_ack  in  1  transaction complete, sampled on posedge
- bus_err  in  1  qualified by bus_ack
- bus_rdata  in  64  read data, qualified by bus_ack

## Operation
- Access: acc = |mem_load_type | |mem_store_type. A store takes priority if both are nonzero.
- Hit: acc & window hit & ~flush.
- FSM states IDLE, REQ, DONE.
- IDLE
  - On hit, latch addr, type, signedness, wdata and we.
  - Aligned access goes to REQ.
  - Misaligned access goes to DONE with err set and no bus activity. Misaligned means word with addr[1:0]≠0, or dword with addr[2:0]≠0.
- REQ
  - bus_req=1.
  - On bus_ack: capture bus_rdata and err=bus_err, then go to DONE.
  - Else if tcnt==TIMEOUT: err=1, rdata=0, go to DONE.
  - Else increment tcnt. tcnt clears on REQ entry.
- DONE
  - One cycle, then IDLE unconditionally.
  - A new hit is not accepted in DONE.
- Strobes: byte = 1<<addr[2:0]; word = addr[2] ? 8'hF0 : 8'h0F; dword = 8'hFF. bus_wdata replicates the byte or word across all lanes.
- Load extraction, from the captured data:
  - byte: lane addr[2:0] (0 = bits 7:0).
  - word: addr[2] ? [63:32] : [31:0].
  - Zero- or sign-extend per load_signed.
  - On err, d_rdata = 0.
- Combinational outputs:
  - stall = (IDLE & hit) | REQ.
  - d_ready = (IDLE & hit) | REQ | (DONE & ~killed).
  - d_valid = DONE & load & ~killed.
  - d_err = DONE & err & ~killed.
- Flush in REQ sets killed. The bus transaction still completes, but DONE asserts none of d_valid, d_ready or d_err.
- bus_addr, bus_we, bus_wdata and bus_wstrb are stable from REQ entry until the cycle after bus_ack.

## Timing
- Reset values: state=IDLE, tcnt=0, killed=0, captured data 0. All registered bus outputs are 0. stall, d_valid, d_ready and d_err are 0 whenever inputs are idle.
- Reset in REQ returns to IDLE immediately and drops bus_req asynchronously. There is no completion pulse.
- Accept at cycle T (stall=1). bus_req is high from T+1. If bus_ack arrives at T+k (k≥1), DONE is T+k+1: stall=0, d_valid=1, and core_MEM captures the data that edge.
- Minimum MMIO load/store stall is 2 cycles.
- Misaligned access: accept T, DONE T+1, 1 stall cycle.
- Timeout: DONE at T+TIMEOUT+2.
- Non-window accesses never stall. In that case d_valid and d_ready stay 0.

## Test plan
- Load from 0xFFFF_FFFF_FFFF_0014, byte, signed, bus_rdata=64'h0000_0080_0000_0000, ack at T+1:
  - stall at T and T+1; bus_wstrb=8'h10.
  - d_valid at T+2 with d_rdata=64'hFFFF_FFFF_FFFF_FF80.
- Store word 0x1234_5678 to 0xFFFF_FFFF_FFFF_0004, ack at T+3:
  - bus_we=1, bus_wstrb=8'hF0, bus_wdata=64'h1234_5678_1234_5678.
  - d_ready high T through T+4, d_valid never asserted, stall drops at T+4.
- No ack with TIMEOUT=255:
  - d_err and d_valid pulse at T+257 with d_rdata=0, then IDLE.
- Misaligned dword load at 0xFFFF_FFFF_FFFF_0003:
  - bus_req never asserts; d_err and d_valid at T+1 with d_rdata=0.
- Flush during REQ, ack at T+2:
  - DONE at T+3 with d_valid=d_ready=d_err=0.
  - A flush coinciding with a hit in IDLE causes no stall.
- Reset asserted mid-REQ:
  - bus_req=0 and stall=0 immediately.
  - A subsequent load to 0x0000_0000_0000_0100 (non-window) produces no stall and no d_valid.
